uart_cmd_rx: RTL and testbench
==============================

UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 Parameter CLK_DIV, default 16'd320, means clk cycles per UART bit (36.864 MHz / 320 = 115200 baud).
REQ-002 Parameter MAX_VAL, default 16'd32767, means the saturation magnitude of the decoded value.
REQ-003 clk  input  1  is the single clock; all logic is clocked on its rising edge.
REQ-004 rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 i_uart_rx  input  1  is the asynchronous UART line, 8 data bits, no parity, 1 stop bit, LSB first, idle high.
REQ-006 o_en  output  1  is a one-cycle pulse indicating a new valid o_val.
REQ-007 o_val  output  16  is the signed decoded value, held between o_en pulses.
REQ-008 o_err  output  1  is a one-cycle pulse indicating a discarded line.

Function -- byte receiver
REQ-009 i_uart_rx SHALL pass through a 2-flop synchronizer before any use; this adds 2 cycles of latency.
REQ-010 Receiver states SHALL be IDLE, START, DATA, STOP.
REQ-011 IDLE -> START SHALL occur on a synchronized high-to-low transition; the bit counter then clears.
REQ-012 START SHALL sample at CLK_DIV/2 cycles: line low -> DATA; line high -> IDLE as a glitch, with no byte and no error.
REQ-013 DATA SHALL sample each bit CLK_DIV cycles after the previous sample, shifting LSB first, for 8 samples, then go to STOP.
REQ-014 STOP SHALL sample one CLK_DIV later: line high -> byte valid (internal 1-cycle strobe); line low -> framing error; either outcome -> IDLE.
REQ-015 After a framing error, IDLE SHALL not re-arm until the line has been sampled high once, so that a break condition is not treated as repeated start bits.

Function -- line parser
REQ-016 Parser states SHALL be EMPTY, SIGN, NUM, ERR.
REQ-017 Line grammar SHALL be an optional '-' (0x2D), then 1 or more digits '0'-'9', then a terminator of CR (0x0D) or LF (0x0A).
REQ-018 EMPTY: digit -> NUM; '-' -> SIGN with the neg flag set; terminator -> stay in EMPTY with no output (CR+LF pairs and blank lines are silent); any other byte -> ERR.
REQ-019 SIGN: digit -> NUM; terminator -> o_err pulse, then EMPTY; any other byte -> ERR.
REQ-020 NUM: digit -> mag = min(mag*10 + digit, MAX_VAL), using a 20-bit intermediate so no wrap is possible; leading zeros and more than 5 digits are accepted, and once saturated the value stays saturated.
REQ-021 NUM: terminator -> o_val = neg ? -mag : mag, with a one-cycle o_en pulse, then EMPTY; any other byte -> ERR.
REQ-022 ERR: all bytes SHALL be ignored until a terminator; on the terminator, a one-cycle o_err pulse, then EMPTY, and o_val is unchanged.
REQ-023 A framing error SHALL force the parser to ERR, whatever its current state.
REQ-024 o_en/o_err SHALL assert exactly 1 cycle after the byte-valid strobe of the terminator byte, which is 2 cycles after the stop-bit sample.
REQ-025 o_en and o_err SHALL never assert in the same cycle.
REQ-026 The range of o_val SHALL be -MAX_VAL..+MAX_VAL, and -32768 SHALL never be produced.
REQ-027 mag and neg SHALL clear on every entry to EMPTY.

Reset
REQ-028 On rst=1, the receiver SHALL enter IDLE and the parser SHALL enter EMPTY; o_en=0, o_err=0, o_val=16'sd0, mag=0, neg=0, and the synchronizer flops are set to 1.
REQ-029 If rst asserts mid-byte or mid-line, the partial byte and partial line SHALL be discarded without o_en/o_err; after reset release, the first high-to-low edge restarts reception.

Verification
REQ-030 Send "200\r" at CLK_DIV=320 -> exactly one o_en pulse with o_val=16'sd200, 2 cycles after the stop-bit sample of 0x0D; o_err stays 0.
REQ-031 Send "-200\r\n" -> one o_en pulse with o_val=-200; the trailing LF produces no pulse.
REQ-032 Send "99999\n" then "-000040000\n" -> o_val=32767, then o_val=-32767, each with one o_en pulse.
REQ-033 Send "12a4\n", then "-\n", then a byte with stop bit=0 followed by "7\n" -> three o_err pulses; o_val is unchanged by all three; no o_en pulse.
REQ-034 Drive a 100-cycle low glitch on idle i_uart_rx -> no byte strobe, no o_en, no o_err; the next "5\n" yields o_val=5.
REQ-035 Assert rst for 1 cycle after "12" of "123\n" has been sent, then send "7\n" -> the only response is o_en with o_val=7.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: a UART byte receiver (8N1, LSB first) feeding a line parser
// that decodes signed decimal lines such as "-123\r" into a saturated
// 16-bit value. o_en pulses for each good line; o_err pulses for each
// discarded line.
module uart_cmd_rx #(
   parameter logic [15:0] CLK_DIV = 16'd320,
   parameter logic [15:0] MAX_VAL = 16'd32767
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_uart_rx,
   output logic               o_en,
   output logic signed [15:0] o_val,
   output logic               o_err
);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
   typedef enum logic [1:0] {P_EMPTY, P_SIGN, P_NUM, P_ERR} p_state_t;

   localparam logic [15:0] HALF_M1 = (CLK_DIV >> 1) - 16'd1;
   localparam logic [15:0] BIT_M1  = CLK_DIV - 16'd1;

   // ---------------- synchronizer ----------------
   logic rx_meta_q, rx_sync_q, rx_prev_q;

   // Two-flop synchronizer plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= i_uart_rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // ---------------- byte receiver ----------------
   r_state_t    r_state_q, r_state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        armed_q, armed_d;
   logic        byte_vld_q, byte_vld_d;
   logic        frame_err_q, frame_err_d;
   logic        tick;

   // The start bit is sampled half a bit in; every later sample is one full bit on.
   assign tick = (r_state_q == R_START) ? (cnt_q == HALF_M1) : (cnt_q == BIT_M1);

   // Receiver state and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q   <= R_IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         armed_q     <= 1'b1;
         byte_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         r_state_q   <= r_state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         armed_q     <= armed_d;
         byte_vld_q  <= byte_vld_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Receiver next-state logic.
   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (armed_q && rx_prev_q && !rx_sync_q) r_state_d = R_START;
         R_START: if (tick) r_state_d = rx_sync_q ? R_IDLE : R_DATA;
         R_DATA:  if (tick && (bit_cnt_q == 3'd7)) r_state_d = R_STOP;
         R_STOP:  if (tick) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // Receiver datapath and strobes; armed_q drops on a framing error so a
   // held-low break is not mistaken for a stream of start bits.
   always_comb begin
      cnt_d       = cnt_q + 16'd1;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      armed_d     = armed_q;
      byte_vld_d  = 1'b0;
      frame_err_d = 1'b0;
      if ((r_state_q == R_IDLE) || tick) cnt_d = '0;
      if (r_state_q == R_IDLE) bit_cnt_d = '0;
      if ((r_state_q == R_DATA) && tick) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
         shift_d   = {rx_sync_q, shift_q[7:1]};
      end
      if ((r_state_q == R_STOP) && tick) begin
         byte_vld_d  = rx_sync_q;
         frame_err_d = !rx_sync_q;
      end
      if (frame_err_d) armed_d = 1'b0;
      else if ((r_state_q == R_IDLE) && rx_sync_q) armed_d = 1'b1;
   end

   // ---------------- line parser ----------------
   p_state_t    p_state_q, p_state_d;
   logic [15:0] mag_q, mag_d;
   logic        neg_q, neg_d;
   logic [15:0] val_q, val_d;
   logic        en_q, en_d;
   logic        err_q, err_d;
   logic        is_digit, is_minus, is_term, got_byte;
   logic [19:0] prod;
   logic [15:0] sat;

   assign got_byte = byte_vld_q && !frame_err_q;
   assign is_digit = (shift_q >= 8'h30) && (shift_q <= 8'h39);
   assign is_minus = (shift_q == 8'h2D);
   assign is_term  = (shift_q == 8'h0D) || (shift_q == 8'h0A);
   // 20 bits hold MAX_VAL*10+9 without wrapping.
   assign prod     = ({4'd0, mag_q} * 20'd10) + {16'd0, shift_q[3:0]};
   assign sat      = (prod > {4'd0, MAX_VAL}) ? MAX_VAL : prod[15:0];

   // Parser state and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_state_q <= P_EMPTY;
         mag_q     <= '0;
         neg_q     <= 1'b0;
         val_q     <= '0;
         en_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         p_state_q <= p_state_d;
         mag_q     <= mag_d;
         neg_q     <= neg_d;
         val_q     <= val_d;
         en_q      <= en_d;
         err_q     <= err_d;
      end
   end

   // Parser next-state logic; a framing error overrides everything.
   always_comb begin
      p_state_d = p_state_q;
      if (frame_err_q) begin
         p_state_d = P_ERR;
      end else if (byte_vld_q) begin
         case (p_state_q)
            P_EMPTY: begin
               if (is_digit)      p_state_d = P_NUM;
               else if (is_minus) p_state_d = P_SIGN;
               else if (is_term)  p_state_d = P_EMPTY;
               else               p_state_d = P_ERR;
            end
            P_SIGN, P_NUM: begin
               if (is_digit)     p_state_d = P_NUM;
               else if (is_term) p_state_d = P_EMPTY;
               else              p_state_d = P_ERR;
            end
            P_ERR:   if (is_term) p_state_d = P_EMPTY;
            default: p_state_d = P_EMPTY;
         endcase
      end
   end

   // Parser outputs: value update, pulses, and magnitude/sign accumulation.
   always_comb begin
      en_d  = got_byte && is_term && (p_state_q == P_NUM);
      err_d = got_byte && is_term && ((p_state_q == P_SIGN) || (p_state_q == P_ERR));
      mag_d = mag_q;
      neg_d = neg_q;
      val_d = val_q;
      if (en_d) val_d = neg_q ? (16'd0 - mag_q) : mag_q;
      if (p_state_d == P_EMPTY) begin
         mag_d = '0;
         neg_d = 1'b0;
      end else if (got_byte && is_digit && (p_state_q != P_ERR)) begin
         mag_d = sat;
      end else if (got_byte && is_minus && (p_state_q == P_EMPTY)) begin
         neg_d = 1'b1;
      end
   end

   assign o_en  = en_q;
   assign o_err = err_q;
   assign o_val = $signed(val_q);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: drives UART frames, pushes the expected pulse
// (kind + o_val) when a terminator is sent, and pops/compares on each pulse.
module tb_uart_cmd_rx;
  // Shortened bit time keeps the run small; glitch length is scaled with it.
  localparam logic [15:0] DIV = 16'd64;
  localparam int D = 64;
  localparam int H = 32;
  localparam int GLITCH = 20; // 100 of 320 cycles, scaled to DIV
  localparam int LATENCY = 4 + H + 9 * D; // start-bit drive to first o_en sample
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic clk;
  logic rst;
  logic rx;
  logic o_en;
  logic o_err;
  logic signed [15:0] o_val;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last_start_cyc = 0;
  int en_cyc = 0;
  logic [16:0] exp_q[$];
  logic [16:0] e;

  uart_cmd_rx #(.CLK_DIV(DIV), .MAX_VAL(16'd32767)) dut (
    .clk(clk),
    .rst(rst),
    .i_uart_rx(rx),
    .o_en(o_en),
    .o_val(o_val),
    .o_err(o_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    last_start_cyc = cyc;
    rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (D) @(negedge clk);
    end
    rx = stop_bit;
    repeat (D - 1) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic push_en(input logic [15:0] v);
    exp_q.push_back({1'b0, v});
  endtask

  task automatic push_err(input logic [15:0] v);
    exp_q.push_back({1'b1, v});
  endtask

  task automatic wait_drain;
    for (int i = 0; i < 4 * D; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // scoreboard: every pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (o_en || o_err) begin
      chk("en_err_exclusive", {31'd0, o_en & o_err}, 0);
      if (o_en) en_cyc = cyc;
      compared++;
      assert (exp_q.size() != 0) else begin
        mismatched++;
        $error("FAIL unexpected_pulse: observed en=%0b err=%0b val=%0d expected none", o_en, o_err, o_val);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pulse_kind_err", {31'd0, o_err}, {31'd0, e[16]});
        chk("o_val", {16'd0, o_val}, {16'd0, e[15:0]});
      end
    end
  end

  // directed sequence
  initial begin
    rst = 1'b1;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_en", {31'd0, o_en}, 0);
    chk("reset_err", {31'd0, o_err}, 0);
    chk("reset_val", {16'd0, o_val}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // "200\r" with exact latency from the CR start bit
    send_str("200");
    push_en(16'd200);
    send_byte(CR, 1'b1);
    wait_drain();
    chk("latency_200", en_cyc - last_start_cyc, LATENCY);

    // "-200\r\n": LF after CR is silent
    send_str("-200");
    push_en(16'hFF38);
    send_byte(CR, 1'b1);
    send_byte(LF, 1'b1);
    wait_drain();

    // saturation both signs
    send_str("99999");
    push_en(16'd32767);
    send_byte(LF, 1'b1);
    wait_drain();
    send_str("-000040000");
    push_en(16'h8001);
    send_byte(LF, 1'b1);
    wait_drain();

    // three discarded lines, o_val held at -32767
    send_str("12a4");
    push_err(16'h8001);
    send_byte(LF, 1'b1);
    wait_drain();
    send_str("-");
    push_err(16'h8001);
    send_byte(LF, 1'b1);
    wait_drain();
    send_byte(8'h31, 1'b0);
    repeat (2 * D) @(negedge clk);
    send_str("7");
    push_err(16'h8001);
    send_byte(LF, 1'b1);
    wait_drain();

    // short low glitch on an idle line
    @(negedge clk);
    rx = 1'b0;
    repeat (GLITCH) @(negedge clk);
    rx = 1'b1;
    repeat (2 * D) @(negedge clk);
    chk("glitch_silent", exp_q.size(), 0);
    send_str("5");
    push_en(16'd5);
    send_byte(LF, 1'b1);
    wait_drain();

    // reset mid-line discards "12"
    send_str("12");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midline_reset_val", {16'd0, o_val}, 0);
    repeat (D) @(negedge clk);
    send_str("7");
    push_en(16'd7);
    send_byte(LF, 1'b1);
    wait_drain();

    repeat (2 * D) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
